// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light mode units and their supervisor:
// light codes, phase durations and the supervisor FSM state encoding.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_UNDEF  = 2'b11;

  // Phase durations in 1 Hz ticks; the supervisor watchdog must exceed the longest.
  localparam int YELLOW_SEC = 3;
  localparam int GREEN_SEC  = 15;

  typedef enum logic [1:0] {
    SUP_IDLE    = 2'd0,
    SUP_RUN     = 2'd1,
    SUP_PENDING = 2'd2,
    SUP_FAULT   = 2'd3
  } sup_state_e;

endpackage

// File: rtl/feedback_edge_det.sv
// Per-bit rising-edge detector. The rise flag is registered, so it appears
// one clk after the level was first sampled high.
module feedback_edge_det #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;

  // Remember last level and flag 0->1 transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= level_i;
      rise_q <= level_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/mode_supervisor.sv
// Mode supervisor: enables one traffic-light mode unit at a time, defers
// operator mode switches to the next phase boundary of the active unit,
// forwards the active unit's light state and trips a watchdog on stalls.
module mode_supervisor
  import traffic_pkg::*;
#(
  parameter int N_MODES      = 4,
  parameter int DEFAULT_MODE = 0,
  parameter int WD_SEC       = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 run,
  input  logic [2:0]           mode_req,
  input  logic                 mode_req_valid,
  input  logic [N_MODES-1:0]   feedback_i,
  input  logic [2*N_MODES-1:0] state_i,
  output logic [N_MODES-1:0]   enb,
  output logic                 set,
  output logic [1:0]           last_state,
  output logic [2:0]           active_mode,
  output logic                 switch_pending,
  output logic                 switch_done,
  output logic                 fault,
  output logic [15:0]          phase_cnt
);

  localparam int         WD_W    = $clog2(WD_SEC + 1);
  localparam logic [2:0] DEF_IDX = 3'(DEFAULT_MODE);
  localparam logic [3:0] N_LIM   = 4'(N_MODES);

  function automatic logic [N_MODES-1:0] onehot(input logic [2:0] idx);
    logic [N_MODES-1:0] v;
    v = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (idx == 3'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  sup_state_e         state_q, state_d;
  logic [N_MODES-1:0] enb_q, enb_d;
  logic               set_q, set_d;
  logic [1:0]         last_q, last_d;
  logic [2:0]         active_q, active_d;
  logic [2:0]         target_q, target_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [N_MODES-1:0] fb_rise_vec;
  logic               fb_rise;
  logic [1:0]         cur_light;
  logic               req_in_range;
  logic [2:0]         next_tgt;
  logic               wd_trip;

  feedback_edge_det #(.WIDTH(N_MODES)) u_fb_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (feedback_i),
    .rise_o  (fb_rise_vec)
  );

  // Pick the active unit's feedback edge and light report; others are ignored
  always_comb begin
    fb_rise   = 1'b0;
    cur_light = LIGHT_RED;
    for (int k = 0; k < N_MODES; k++) begin
      if (active_q == 3'(k)) begin
        fb_rise   = fb_rise_vec[k];
        cur_light = state_i[2*k +: 2];
      end
    end
  end

  assign req_in_range = ({1'b0, mode_req} < N_LIM);
  assign next_tgt     = (mode_req_valid && req_in_range) ? mode_req : target_q;

  // Next-state logic: request deferral, boundary switch, watchdog, counters
  always_comb begin
    state_d   = state_q;
    enb_d     = enb_q;
    last_d    = last_q;
    active_d  = active_q;
    target_d  = target_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    wd_trip   = 1'b0;
    case (state_q)
      SUP_IDLE: begin
        state_d  = SUP_RUN;
        enb_d    = onehot(DEF_IDX);
        active_d = DEF_IDX;
      end
      SUP_RUN, SUP_PENDING: begin
        if (cur_light != LIGHT_UNDEF) last_d = cur_light;
        if (fb_rise) cnt_d = cnt_q + 16'd1;
        if (fb_rise) begin
          wd_d = '0;
        end else if (tick && set_q && run) begin
          wd_d    = wd_q + WD_W'(1);
          wd_trip = (wd_q == WD_W'(WD_SEC - 1));
        end
        if (wd_trip) begin
          state_d   = SUP_FAULT;
          enb_d     = '0;
          fault_d   = 1'b1;
          pending_d = 1'b0;
        end else if (state_q == SUP_RUN) begin
          // A boundary in the same clk does not serve a fresh request.
          if (mode_req_valid && req_in_range && (mode_req != active_q)) begin
            target_d  = mode_req;
            pending_d = 1'b1;
            state_d   = SUP_PENDING;
          end
        end else if (mode_req_valid && (mode_req == active_q)) begin
          pending_d = 1'b0;
          state_d   = SUP_RUN;
        end else begin
          target_d = next_tgt;
          if (fb_rise) begin
            enb_d     = onehot(next_tgt);
            active_d  = next_tgt;
            done_d    = 1'b1;
            pending_d = 1'b0;
            state_d   = SUP_RUN;
          end
        end
      end
      SUP_FAULT: begin
      end
      default: begin
        state_d = SUP_IDLE;
      end
    endcase
    set_d = run && ((state_d == SUP_RUN) || (state_d == SUP_PENDING));
  end

  // State and output registers, all returned to reset values by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SUP_IDLE;
      enb_q     <= '0;
      set_q     <= 1'b0;
      last_q    <= LIGHT_RED;
      active_q  <= DEF_IDX;
      target_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      enb_q     <= enb_d;
      set_q     <= set_d;
      last_q    <= last_d;
      active_q  <= active_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
    end
  end

  assign enb            = enb_q;
  assign set            = set_q;
  assign last_state     = last_q;
  assign active_mode    = active_q;
  assign switch_pending = pending_q;
  assign switch_done    = done_q;
  assign fault          = fault_q;
  assign phase_cnt      = cnt_q;

endmodule
